regbank_5bit_reader: RTL and testbench
======================================

// Module: regbank_5bit_reader
// PURPOSE
//   Read-side partner of the 5-bit load-enable register: a small bank of 5-bit
//   registers with one write port (wr_en acts as the load select) and one
//   handshaked read port. The read port lets the datapath and debug logic
//   read stored values back with a registered, flow-controlled response.
//   It sits between the register write path and any consumer that can stall.
// PARAMETERS
//   WIDTH   5   data width of each entry
//   DEPTH   6   number of entries (need not be a power of two)
//   AW      3   address width; must satisfy 2**AW >= DEPTH
// PORTS
//   clk          in   1      system clock, all state updates on rising edge
//   rst_n        in   1      asynchronous, active-low reset
//   wr_en        in   1      write/load select; entry wr_addr loads wr_data
//   wr_addr      in   AW     write address
//   wr_data      in   WIDTH  write data
//   rd_req       in   1      read request, qualified by rd_req_rdy
//   rd_addr      in   AW     read address, sampled on acceptance
//   rd_req_rdy   out  1      read port can accept: !rd_valid || rd_ready
//   rd_valid     out  1      response valid; held until rd_ready
//   rd_data      out  WIDTH  response data, stable while rd_valid && !rd_ready
//   rd_err       out  1      response flag: address was >= DEPTH
//   rd_ready     in   1      consumer takes response when rd_valid && rd_ready
// BEHAVIOUR
//   One clock; reset is asynchronous and active-low.
//   Reset (rst_n=0, any time): all entries=0, rd_valid=0, rd_data=0, rd_err=0,
//     state=IDLE. Reset mid-response drops the pending response silently.
//   Write: on posedge with wr_en=1 and wr_addr<DEPTH, entry loads wr_data.
//     wr_addr>=DEPTH: write ignored, no entry changes.
//   Accept: acc = rd_req && rd_req_rdy. rd_req_rdy is combinational.
//   Latency: response appears exactly 1 cycle after acceptance (rd_valid=1 on
//     the edge that sampled rd_req).
//   Read data on accept:
//     rd_addr>=DEPTH -> rd_data=0, rd_err=1.
//     wr_en && wr_addr==rd_addr in the same cycle -> rd_data=wr_data (bypass).
//     otherwise -> rd_data=entry[rd_addr], rd_err=0.
//   Captured response is a snapshot: later writes to that entry do not alter
//     rd_data while it is held.
//   FSM (state == rd_valid):
//     IDLE : acc -> VALID (load rd_data/rd_err); else stay.
//     VALID: rd_ready && acc  -> VALID, new data loaded (back-to-back, 1/clk).
//            rd_ready && !acc -> IDLE, rd_valid=0 (rd_data keeps last value).
//            !rd_ready        -> stay, rd_data/rd_err frozen, rd_req_rdy=0.
//   rd_req while rd_req_rdy=0 is not accepted; requester must hold it.
//   Throughput: one read per clock when rd_ready held high.
//   Writes are never blocked by read-port stalls.
// TESTING
//   Reset: rst_n=0 mid-sim with rd_valid=1 -> rd_valid=0, all entries read 0.
//   Write 5'b10011 to addr 2, next cycle read addr 2 -> 1 clk later
//     rd_valid=1, rd_data=5'b10011, rd_err=0.
//   Same-cycle wr addr 3 data 5'b01111 and rd addr 3 (old 0) -> rd_data=5'b01111.
//   rd_ready=0 for 3 cycles with response 5'b10011 pending, write addr 2 =
//     5'b00001 meanwhile -> rd_data stays 5'b10011, rd_req_rdy=0 throughout.
//   Read addr 6 (DEPTH=6) -> rd_err=1, rd_data=0; write to addr 7 changes nothing.
//   rd_ready=1, rd_req held over addrs 0..5 -> six responses on consecutive
//     cycles, in order, matching written values.

Source files
------------

// File: rtl/regbank_5bit_reader.sv
// regbank_5bit_reader
//   A small bank of WIDTH-bit registers with one write port and one
//   flow-controlled read port. The read port returns a registered response
//   one clock after a request is accepted and holds that response until the
//   consumer takes it. Writes are never blocked by read-side stalls.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   wr_en       write/load select: entry wr_addr loads wr_data
//   wr_addr     write address (addresses >= DEPTH are ignored)
//   wr_data     write data
//   rd_req      read request, taken only while rd_req_rdy is high
//   rd_addr     read address, sampled on acceptance
//   rd_req_rdy  read port can accept this cycle (!rd_valid || rd_ready)
//   rd_valid    response valid, held until rd_ready
//   rd_data     response data, frozen while rd_valid && !rd_ready
//   rd_err      response flag: requested address was >= DEPTH
//   rd_ready    consumer takes the response when rd_valid && rd_ready
module regbank_5bit_reader #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 6,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_req,
   input  logic [AW-1:0]    rd_addr,
   output logic             rd_req_rdy,
   output logic             rd_valid,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_err,
   input  logic             rd_ready
);

   // The response register doubles as the FSM: state is exactly rd_valid.
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] VALID = 1'b1;

   // DEPTH widened by one bit so the range check also works when
   // DEPTH == 2**AW.
   localparam logic [AW:0] DEPTH_EXT = (AW+1)'(DEPTH);

   logic [0:0]       state_reg;
   logic [0:0]       state_next;
   logic [WIDTH-1:0] data_reg;
   logic [WIDTH-1:0] data_next;
   logic             err_reg;
   logic             err_next;

   logic [WIDTH-1:0] entry_q [DEPTH];
   logic [WIDTH-1:0] rd_sel;
   logic             rd_in_range;
   logic             rd_bypass;
   logic             acc;
   logic [WIDTH-1:0] load_data;
   logic             load_err;

   // ------------------------------------------------------------------
   // Storage: one register per entry. Each entry decodes its own write
   // select, so an out-of-range wr_addr simply matches no entry.
   // Plain flops rather than a RAM: the bank must clear asynchronously
   // and the read path needs a same-cycle write bypass.
   // ------------------------------------------------------------------
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_reg;
      logic             entry_hit;

      assign entry_hit = wr_en && (wr_addr == AW'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            entry_reg <= '0;
         end else if (entry_hit) begin
            entry_reg <= wr_data;
         end
      end

      assign entry_q[gi] = entry_reg;
   end

   // ------------------------------------------------------------------
   // Read selection
   // ------------------------------------------------------------------
   assign rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);

   always_comb begin
      rd_sel = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (rd_addr == AW'(i)) begin
            rd_sel = entry_q[i];
         end
      end
   end

   // A write landing on the entry being read in the same cycle wins, so the
   // response reflects the value the entry holds after this edge.
   assign rd_bypass = wr_en && (wr_addr == rd_addr);

   always_comb begin
      load_data = rd_sel;
      load_err  = 1'b0;
      if (!rd_in_range) begin
         load_data = '0;
         load_err  = 1'b1;
      end else if (rd_bypass) begin
         load_data = wr_data;
      end
   end

   // ------------------------------------------------------------------
   // Handshake and response FSM
   // ------------------------------------------------------------------
   // A held response that is being consumed this cycle frees the slot,
   // which is what allows one read per clock.
   assign rd_req_rdy = (state_reg == IDLE) || rd_ready;
   assign acc        = rd_req && rd_req_rdy;

   always_comb begin
      state_next = state_reg;
      data_next  = data_reg;
      err_next   = err_reg;
      case (state_reg)
         IDLE: begin
            if (acc) begin
               state_next = VALID;
               data_next  = load_data;
               err_next   = load_err;
            end
         end
         VALID: begin
            if (rd_ready) begin
               if (acc) begin
                  data_next = load_data;
                  err_next  = load_err;
               end else begin
                  // rd_data keeps its last value once the slot empties.
                  state_next = IDLE;
               end
            end
            // !rd_ready: response frozen, acc is impossible (rd_req_rdy=0).
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         data_reg  <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         data_reg  <= data_next;
         err_reg   <= err_next;
      end
   end

   assign rd_valid = (state_reg == VALID);
   assign rd_data  = data_reg;
   assign rd_err   = err_reg;

endmodule

// File: tb/tb_regbank_5bit_reader.sv
// tb_regbank_5bit_reader
//   Self-checking bench for regbank_5bit_reader. A reference model holds the
//   bank contents in an array and outstanding responses in a queue; every
//   scenario task compares the DUT against it (and against fixed values
//   where the scenario defines them).
module tb_regbank_5bit_reader;

   localparam int WIDTH = 5;
   localparam int DEPTH = 6;
   localparam int AW    = 3;

   logic             clk;
   logic             rst_n;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic             rd_req;
   logic [AW-1:0]    rd_addr;
   logic             rd_req_rdy;
   logic             rd_valid;
   logic [WIDTH-1:0] rd_data;
   logic             rd_err;
   logic             rd_ready;

   int n_tests;
   int n_fail;

   // Reference model
   logic [WIDTH-1:0] m_mem [DEPTH];
   logic [WIDTH:0]   m_q [$];     // pending responses {err, data}
   logic [WIDTH:0]   m_last;      // last captured response
   logic             g_exp_rdy;
   logic             g_obs_rdy;

   regbank_5bit_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_req     (rd_req),
      .rd_addr    (rd_addr),
      .rd_req_rdy (rd_req_rdy),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data),
      .rd_err     (rd_err),
      .rd_ready   (rd_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_q.delete();
      m_last = '0;
   endtask

   // Drives one cycle of inputs (called at posedge+1), samples rd_req_rdy,
   // advances the model across the clock edge and returns at posedge+1.
   task automatic cycle(input logic wen, input logic [AW-1:0] waddr,
                        input logic [WIDTH-1:0] wdata, input logic req,
                        input logic [AW-1:0] raddr, input logic ready);
      logic [WIDTH:0] resp;
      wr_en    = wen;
      wr_addr  = waddr;
      wr_data  = wdata;
      rd_req   = req;
      rd_addr  = raddr;
      rd_ready = ready;
      #1;
      g_exp_rdy = (m_q.size() == 0) || ready;
      g_obs_rdy = rd_req_rdy;
      if (int'(raddr) >= DEPTH)              resp = {1'b1, {WIDTH{1'b0}}};
      else if (wen && waddr == raddr)        resp = {1'b0, wdata};
      else                                   resp = {1'b0, m_mem[raddr]};
      if (m_q.size() != 0 && ready) void'(m_q.pop_front());
      if (req && g_exp_rdy) begin
         m_q.push_back(resp);
         m_last = resp;
      end
      if (wen && int'(waddr) < DEPTH) m_mem[waddr] = wdata;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      n_tests++;
      if (rd_valid !== 1'b0 || rd_data !== 5'b0 || rd_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got valid=%b data=%b err=%b, required 0/00000/0",
                  rd_valid, rd_data, rd_err);
      end
      n_tests++;
      if (rd_req_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_rdy: got %b, required 1", rd_req_rdy);
      end
      $display("[TB] test_reset done");
   endtask

   task automatic test_write_read();
      cycle(1'b1, 3'd2, 5'b10011, 1'b0, 3'd0, 1'b1);
      cycle(1'b0, 3'd0, 5'b0, 1'b1, 3'd2, 1'b1);
      n_tests++;
      if (rd_valid !== 1'b1 || rd_data !== 5'b10011 || rd_err !== 1'b0) begin
         n_fail++;
         $display("FAIL write_read: got valid=%b data=%b err=%b, required 1/10011/0",
                  rd_valid, rd_data, rd_err);
      end
      $display("[TB] write_read addr2 data=%b", rd_data);
   endtask

   task automatic test_bypass();
      cycle(1'b1, 3'd3, 5'b01111, 1'b1, 3'd3, 1'b1);
      n_tests++;
      if (rd_valid !== 1'b1 || rd_data !== 5'b01111 || rd_err !== 1'b0) begin
         n_fail++;
         $display("FAIL bypass: got valid=%b data=%b err=%b, required 1/01111/0",
                  rd_valid, rd_data, rd_err);
      end
      $display("[TB] bypass addr3 data=%b", rd_data);
   endtask

   task automatic test_stall();
      cycle(1'b0, 3'd0, 5'b0, 1'b1, 3'd2, 1'b1);
      for (int c = 0; c < 3; c++) begin
         cycle(1'b1, 3'd2, 5'b00001, 1'b1, 3'd0, 1'b0);
         n_tests++;
         if (g_obs_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_rdy c%0d: got %b, required 0", c, g_obs_rdy);
         end
         n_tests++;
         if (rd_valid !== 1'b1 || rd_data !== 5'b10011 || rd_err !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hold c%0d: got valid=%b data=%b, required 1/10011",
                     c, rd_valid, rd_data);
         end
         $display("[TB] stall c%0d data=%b rdy=%b", c, rd_data, g_obs_rdy);
      end
      cycle(1'b0, 3'd0, 5'b0, 1'b1, 3'd2, 1'b1);
      n_tests++;
      if (g_obs_rdy !== 1'b1 || rd_valid !== 1'b1 || rd_data !== 5'b00001) begin
         n_fail++;
         $display("FAIL stall_release: got rdy=%b valid=%b data=%b, required 1/1/00001",
                  g_obs_rdy, rd_valid, rd_data);
      end
      $display("[TB] stall release data=%b", rd_data);
   endtask

   task automatic test_out_of_range();
      cycle(1'b0, 3'd0, 5'b0, 1'b1, 3'd6, 1'b1);
      n_tests++;
      if (rd_valid !== 1'b1 || rd_err !== 1'b1 || rd_data !== 5'b0) begin
         n_fail++;
         $display("FAIL oor_read6: got valid=%b err=%b data=%b, required 1/1/00000",
                  rd_valid, rd_err, rd_data);
      end
      $display("[TB] oor read addr6 err=%b", rd_err);
      cycle(1'b1, 3'd7, 5'b11111, 1'b1, 3'd7, 1'b1);
      n_tests++;
      if (rd_err !== 1'b1 || rd_data !== 5'b0) begin
         n_fail++;
         $display("FAIL oor_wr7_rd7: got err=%b data=%b, required 1/00000", rd_err, rd_data);
      end
      $display("[TB] oor write/read addr7 err=%b", rd_err);
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1'b0, 3'd0, 5'b0, 1'b1, AW'(i), 1'b1);
         n_tests++;
         if (rd_valid !== 1'b1 || {rd_err, rd_data} !== m_last) begin
            n_fail++;
            $display("FAIL oor_unchanged a%0d: got err=%b data=%b, required %b",
                     i, rd_err, rd_data, m_last);
         end
         $display("[TB] post-oor read a%0d data=%b", i, rd_data);
      end
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] vals [DEPTH];
      for (int i = 0; i < DEPTH; i++) begin
         vals[i] = WIDTH'($urandom_range(0, 31));
         cycle(1'b1, AW'(i), vals[i], 1'b0, 3'd0, 1'b1);
      end
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1'b0, 3'd0, 5'b0, 1'b1, AW'(i), 1'b1);
         n_tests++;
         if (g_obs_rdy !== 1'b1 || rd_valid !== 1'b1 || rd_data !== vals[i] || rd_err !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b a%0d: got rdy=%b valid=%b data=%b err=%b, required 1/1/%b/0",
                     i, g_obs_rdy, rd_valid, rd_data, rd_err, vals[i]);
         end
         $display("[TB] b2b a%0d data=%b", i, rd_data);
      end
      cycle(1'b0, 3'd0, 5'b0, 1'b0, 3'd0, 1'b1);
      n_tests++;
      if (rd_valid !== 1'b0 || rd_data !== vals[DEPTH-1]) begin
         n_fail++;
         $display("FAIL b2b_drain: got valid=%b data=%b, required 0/%b",
                  rd_valid, rd_data, vals[DEPTH-1]);
      end
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      for (int c = 0; c < 400; c++) begin
         cycle(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
               WIDTH'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
               AW'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
         n_tests++;
         if (g_obs_rdy !== g_exp_rdy || rd_valid !== (m_q.size() != 0) ||
             rd_data !== m_last[WIDTH-1:0] || rd_err !== m_last[WIDTH]) begin
            n_fail++;
            errs++;
            $display("FAIL random c%0d: got rdy=%b valid=%b err=%b data=%b, required rdy=%b valid=%b err=%b data=%b",
                     c, g_obs_rdy, rd_valid, rd_err, rd_data,
                     g_exp_rdy, (m_q.size() != 0), m_last[WIDTH], m_last[WIDTH-1:0]);
         end
      end
      $display("[TB] random 400 cycles, %0d mismatched cycles", errs);
   endtask

   task automatic test_reset_mid();
      cycle(1'b1, 3'd1, 5'b10101, 1'b1, 3'd1, 1'b0);
      cycle(1'b0, 3'd0, 5'b0, 1'b0, 3'd0, 1'b0);
      n_tests++;
      if (rd_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_pre: got valid=%b, required 1", rd_valid);
      end
      rst_n = 1'b0;
      #1;
      model_clear();
      n_tests++;
      if (rd_valid !== 1'b0 || rd_data !== 5'b0 || rd_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_async: got valid=%b data=%b err=%b, required 0/00000/0",
                  rd_valid, rd_data, rd_err);
      end
      $display("[TB] reset mid-response valid=%b", rd_valid);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1'b0, 3'd0, 5'b0, 1'b1, AW'(i), 1'b1);
         n_tests++;
         if (rd_valid !== 1'b1 || rd_data !== 5'b0 || rd_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_entry a%0d: got valid=%b data=%b, required 1/00000",
                     i, rd_valid, rd_data);
         end
         $display("[TB] post-reset read a%0d data=%b", i, rd_data);
      end
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      wr_en    = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      rd_req   = 1'b0;
      rd_addr  = '0;
      rd_ready = 1'b1;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst_n = 1'b1;
      test_write_read();
      test_bypass();
      test_stall();
      test_out_of_range();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
